// File: rtl/athos_pkg.sv
// Shared types and constants for the athos accelerator.
// Includes the Kyber poly_frommsg lane and sequencer definitions.
package athos_pkg;

  localparam int          KYBER_N      = 256;
  localparam logic [15:0] KYBER_Q_HALF = 16'd1665;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT,
    DONE
  } frommsg_state_e;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
  } in_t;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
  } out_t;

endpackage

// File: rtl/poly_frommsg.sv
// Combinational poly_frommsg lane: picks bit rs2[3:0] of the
// halfword in rs1 and maps it to 0 or q/2 in rd2.
module poly_frommsg
  import athos_pkg::*;
(
  input  in_t  i_in,
  output out_t o_out
);

  logic [15:0] w_h;
  logic        w_bit;
  logic        w_unused;

  assign w_h   = i_in.rs1[15:0];
  assign w_bit = w_h[i_in.rs2[3:0]];

  assign o_out.rd1 = {31'd0, w_bit};
  assign o_out.rd2 = {16'd0, w_bit ? KYBER_Q_HALF : 16'd0};

  assign w_unused = ^{i_in.rs1[31:16], i_in.rs2[31:4]};

endmodule

// File: rtl/poly_frommsg_ctrl.sv
// Sequencer for Kyber poly_frommsg: loads the message words, then
// streams packed coefficient pairs from two datapath lanes.
module poly_frommsg_ctrl
  import athos_pkg::*;
#(
  parameter int MSG_WORDS = KYBER_N / 32,
  parameter int OUT_AW    = 7
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              msg_valid_i,
  output logic              msg_ready_o,
  input  logic [31:0]       msg_data_i,
  output logic              coef_valid_o,
  input  logic              coef_ready_i,
  output logic [OUT_AW-1:0] coef_addr_o,
  output logic [31:0]       coef_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int MSG_W = 32 * MSG_WORDS;
  localparam int NHALF = 2 * MSG_WORDS;
  localparam int WCW   = (MSG_WORDS > 1) ?
                         $clog2(MSG_WORDS) : 1;
  localparam logic [WCW-1:0] WLAST =
    WCW'(MSG_WORDS - 1);
  localparam logic [OUT_AW-1:0] KLAST =
    OUT_AW'(16 * MSG_WORDS - 1);

  frommsg_state_e r_state;
  frommsg_state_e w_next;

  logic [MSG_W-1:0]  r_msg;
  logic [MSG_W-1:0]  w_msg;
  logic [WCW-1:0]    r_wcnt;
  logic [OUT_AW-1:0] r_addr;
  logic [OUT_AW-1:0] w_kn;
  logic [31:0]       r_data;
  logic [31:0]       w_data;
  logic [15:0]       w_halves [NHALF];
  logic [15:0]       w_half;
  logic              w_msg_hs;
  logic              w_coef_hs;
  logic              w_unused;

  in_t  w_in0;
  in_t  w_in1;
  out_t w_out0;
  out_t w_out1;

  assign w_msg_hs  = (r_state == LOAD) & msg_valid_i;
  assign w_coef_hs = (r_state == EMIT) & coef_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (start_i) w_next = LOAD;
      LOAD: if (w_msg_hs && r_wcnt == WLAST)
              w_next = EMIT;
      EMIT: if (w_coef_hs && r_addr == KLAST)
              w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Merge the incoming word so word 0 can be built on the last load edge
  always_comb begin
    w_msg = r_msg;
    for (int w = 0; w < MSG_WORDS; w++) begin
      if (w_msg_hs && r_wcnt == WCW'(w))
        w_msg[32*w +: 32] = msg_data_i;
    end
  end

  always_comb begin
    for (int i = 0; i < NHALF; i++)
      w_halves[i] = w_msg[16*i +: 16];
  end

  assign w_kn   = (r_state == EMIT) ? r_addr + 1'b1 : '0;
  assign w_half = w_halves[w_kn[OUT_AW-1:3]];

  assign w_in0.rs1 = {16'd0, w_half};
  assign w_in0.rs2 = {27'd0, w_kn[2:0], 1'b0};
  assign w_in1.rs1 = {16'd0, w_half};
  assign w_in1.rs2 = {27'd0, w_kn[2:0], 1'b1};

  poly_frommsg u_lane0 (
    .i_in  (w_in0),
    .o_out (w_out0)
  );

  poly_frommsg u_lane1 (
    .i_in  (w_in1),
    .o_out (w_out1)
  );

  assign w_data = {w_out1.rd2[15:0], w_out0.rd2[15:0]};

  assign w_unused = ^{w_out0.rd1, w_out0.rd2[31:16],
                      w_out1.rd1, w_out1.rd2[31:16]};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_msg  <= '0;
      r_wcnt <= '0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      unique case (r_state)
        IDLE: r_wcnt <= '0;
        LOAD: begin
          if (w_msg_hs) begin
            r_msg  <= w_msg;
            r_wcnt <= r_wcnt + 1'b1;
            if (r_wcnt == WLAST) begin
              r_addr <= '0;
              r_data <= w_data;
            end
          end
        end
        EMIT: begin
          if (w_coef_hs && r_addr != KLAST) begin
            r_addr <= w_kn;
            r_data <= w_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    msg_ready_o  = 1'b0;
    coef_valid_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    unique case (r_state)
      IDLE: ;
      LOAD: begin
        msg_ready_o = 1'b1;
        busy_o      = 1'b1;
      end
      EMIT: begin
        coef_valid_o = 1'b1;
        busy_o       = 1'b1;
      end
      DONE: begin
        done_o = 1'b1;
        busy_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign coef_addr_o = r_addr;
  assign coef_data_o = r_data;

endmodule

// File: tb/tb_poly_frommsg_ctrl.sv
// Scoreboard bench for poly_frommsg_ctrl: expected words are queued
// at stimulus time and popped by a monitor on each output handshake.
module tb_poly_frommsg_ctrl;

  localparam int MW = 8;
  localparam int NK = 16 * MW;
  localparam logic [15:0] QH = 16'd1665;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mvalid = 1'b0;
  logic        mready;
  logic [31:0] mdata = '0;
  logic        cvalid;
  logic        cready = 1'b0;
  logic [6:0]  caddr;
  logic [31:0] cdata;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int ready_pct = 100;

  logic [38:0] exp_q [$];
  logic [31:0] msg_w [MW];
  logic        hold_v = 1'b0;
  logic [38:0] held;

  poly_frommsg_ctrl #(
    .MSG_WORDS (MW),
    .OUT_AW    (7)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .msg_valid_i  (mvalid),
    .msg_ready_o  (mready),
    .msg_data_i   (mdata),
    .coef_valid_o (cvalid),
    .coef_ready_i (cready),
    .coef_addr_o  (caddr),
    .coef_data_o  (cdata),
    .busy_o       (busy),
    .done_o       (done)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    cready = (int'($urandom_range(99)) < ready_pct);
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [38:0] e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_valid_low", 64'(cvalid), 64'd0);
      end
      if (cvalid) begin
        if (hold_v)
          chk("stall_stable", 64'({caddr, cdata}), 64'(held));
        if (cready) begin
          hold_v = 1'b0;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL extra_out: got %h want none",
                     {caddr, cdata});
          end else begin
            e = exp_q.pop_front();
            chk("coef", 64'({caddr, cdata}), 64'(e));
          end
        end else begin
          hold_v = 1'b1;
          held   = {caddr, cdata};
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  function automatic logic [31:0] model(input int k);
    logic [255:0] m;
    logic [15:0]  h;
    int           j;
    for (int w = 0; w < MW; w++) m[32*w +: 32] = msg_w[w];
    h = m[16*(k>>3) +: 16];
    j = 2 * (k & 7);
    return {h[j+1] ? QH : 16'd0, h[j] ? QH : 16'd0};
  endfunction

  task automatic push_model();
    for (int k = 0; k < NK; k++)
      exp_q.push_back({7'(k), model(k)});
  endtask

  task automatic push_ones();
    for (int k = 0; k < NK; k++)
      exp_q.push_back({7'(k), 32'h0681_0681});
  endtask

  task automatic push_pattern();
    logic [31:0] d;
    for (int k = 0; k < NK; k++) begin
      d = 32'h0;
      if (k == 0)  d = 32'h0000_0681;
      if (k == 31) d = 32'h0681_0000;
      exp_q.push_back({7'(k), d});
    end
  endtask

  task automatic wait_addr(input int a);
    int n = 0;
    @(negedge clk);
    while (!(cvalid && caddr == 7'(a)) && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 2000) chk("addr_timeout", 64'd1, 64'd0);
  endtask

  task automatic do_run(input int pct, input bit poke,
                        input int abort_k);
    int s;
    int n;
    ready_pct = pct;
    done_cnt  = 0;
    @(posedge clk);
    #1;
    s = cyc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int w = 0; w < MW; w++) begin
      mvalid = 1'b1;
      mdata  = msg_w[w];
      n = 0;
      @(negedge clk);
      while (!mready && n < 20) begin
        n++;
        @(negedge clk);
      end
      if (n >= 20) chk("load_timeout", 64'd1, 64'd0);
      if (w == 0) chk("ready_latency", 64'(cyc - s), 64'd1);
      @(posedge clk);
      #1;
    end
    mvalid = 1'b0;
    mdata  = '0;
    if (abort_k >= 0) begin
      wait_addr(abort_k);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_valid", 64'(cvalid), 64'd0);
      rst_n = 1'b1;
      exp_q.delete();
      repeat (3) @(negedge clk);
      chk("abort_no_done", 64'(done_cnt), 64'd0);
      return;
    end
    if (poke) begin
      wait_addr(10);
      start  = 1'b1;
      mvalid = 1'b1;
      mdata  = 32'hDEAD_BEEF;
      repeat (3) @(posedge clk);
      #1;
      start  = 1'b0;
      mvalid = 1'b0;
      mdata  = '0;
    end
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk("done_seen", 64'(done_cnt), 64'd1);
    if (pct == 100)
      chk("total_cycles", 64'(done_cyc - s + 1),
          64'(2 + 17 * MW));
    repeat (2) @(negedge clk);
    chk("done_single", 64'(done_cnt), 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(cvalid), 64'd0);
    chk("rst_ready", 64'(mready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    for (int w = 0; w < MW; w++) msg_w[w] = 32'hFFFF_FFFF;
    push_ones();
    do_run(100, 1'b0, -1);

    msg_w = '{32'h0000_0001, 32'h8000_0000, 32'h0, 32'h0,
              32'h0, 32'h0, 32'h0, 32'h0};
    push_pattern();
    do_run(100, 1'b0, -1);

    msg_w = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_00FF,
              32'hA5A5_5A5A, 32'h0000_8001, 32'hFFFF_0000,
              32'h1357_9BDF, 32'h8421_4218};
    push_model();
    do_run(30, 1'b0, -1);

    msg_w = '{32'hCAFE_F00D, 32'h0, 32'h0000_FFFF,
              32'h8000_0001, 32'h5555_AAAA, 32'h3C3C_C3C3,
              32'h0001_0000, 32'h7FFF_FFFE};
    push_model();
    do_run(100, 1'b1, -1);

    push_model();
    do_run(100, 1'b0, 40);

    msg_w = '{32'h0BAD_F00D, 32'h1111_2222, 32'h3333_4444,
              32'h5555_6666, 32'h7777_8888, 32'h9999_AAAA,
              32'hBBBB_CCCC, 32'hDDDD_EEEE};
    push_model();
    do_run(100, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
